// File: rtl/sfifo_fill_pkg.sv
// rtl/sfifo_fill_pkg.sv - shared types and helpers for the sync FIFO fill controller
package sfifo_fill_pkg;

    // Address width that never collapses to zero, even for tiny depths.
    function automatic int safe_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic full;
        logic halffull;
        logic almost_full;
        logic empty;
        logic almost_empty;
    } fill_flags_t;

    localparam fill_flags_t FLAGS_RESET = '{
        full:         1'b0,
        halffull:     1'b0,
        almost_full:  1'b0,
        empty:        1'b1,
        almost_empty: 1'b1
    };

    // Occupancy after this cycle's accepted write/read; callers gate wr/rd
    // with the status flags, so the result never leaves [0, depth].
    function automatic logic [31:0] calc_next_fill(input logic [31:0] fill,
                                                   input logic        wr,
                                                   input logic        rd);
        return fill + {31'b0, wr} - {31'b0, rd};
    endfunction

endpackage

// File: rtl/sfifo_fill_ptr.sv
// rtl/sfifo_fill_ptr.sv - wrapping RAM address counter for any depth
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-low reset
//   inc_i  advance the address by one, wrapping from G_DEPTH-1 to 0
//   addr_o current address
module sfifo_fill_ptr
    import sfifo_fill_pkg::*;
#(
    parameter  int G_DEPTH = 1024,
    localparam int AW      = safe_clog2(G_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc_i,
    output logic [AW-1:0] addr_o
);

    localparam logic [AW-1:0] LAST = AW'(G_DEPTH - 1);

    logic [AW-1:0] addr_q, addr_d;

    // Explicit compare against the last index so non-power-of-2 depths wrap.
    always_comb begin
        addr_d = addr_q;
        if (inc_i) begin
            addr_d = (addr_q == LAST) ? '0 : addr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr_o = addr_q;

endmodule

// File: rtl/sfifo_fill_ctrl.sv
// rtl/sfifo_fill_ctrl.sv - sync FIFO control: fill counter, addresses, flags, error status
//
// Ports:
//   clk, rst                      clock (rising) and async active-low reset
//   wr_en, rd_en                  write / read requests
//   af_thresh, ae_thresh          almost-full / almost-empty thresholds (quasi-static)
//   err_clr                       clears sticky error bits (and peak_level when present)
//   wr_ack, rd_ack                request accepted this cycle
//   wr_addr, rd_addr              RAM addresses
//   fill_level                    registered occupancy
//   full, halffull, almost_full,
//   empty, almost_empty           registered status flags
//   overflow, underflow           one-cycle error pulses
//   ovf_sticky, udf_sticky        sticky error bits
//   peak_level                    high-water mark, only with SFIFO_FILL_CTRL_WATERMARK_EN
module sfifo_fill_ctrl
    import sfifo_fill_pkg::*;
#(
    parameter  int G_FWFT     = 0,
    parameter  int G_MEMDEPTH = 1024,
    localparam int AW         = safe_clog2(G_MEMDEPTH),
    localparam int FW         = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic          rd_en,
    input  logic [FW-1:0] af_thresh,
    input  logic [FW-1:0] ae_thresh,
    input  logic          err_clr,
    output logic          wr_ack,
    output logic          rd_ack,
    output logic [AW-1:0] wr_addr,
    output logic [AW-1:0] rd_addr,
    output logic [FW-1:0] fill_level,
    output logic          full,
    output logic          halffull,
    output logic          almost_full,
    output logic          empty,
    output logic          almost_empty,
    output logic          overflow,
    output logic          underflow,
    output logic          ovf_sticky,
    output logic          udf_sticky
`ifdef SFIFO_FILL_CTRL_WATERMARK_EN
    ,
    output logic [FW-1:0] peak_level
`endif
);

    localparam logic [FW-1:0] DEPTH = FW'(G_MEMDEPTH);
    localparam logic [FW-1:0] HALF  = FW'(G_MEMDEPTH / 2);

    logic [FW-1:0] fill_q, fill_d;
    fill_flags_t   flags_q, flags_d;
    logic          r_empty_dly_q;
    logic          overflow_q, underflow_q;
    logic          ovf_sticky_q, ovf_sticky_d;
    logic          udf_sticky_q, udf_sticky_d;
    logic          ovf_evt, udf_evt;

    // Gate on the internal registered empty, never the FWFT-widened output.
    assign wr_ack  = wr_en & ~flags_q.full;
    assign rd_ack  = rd_en & ~flags_q.empty;
    assign ovf_evt = wr_en & flags_q.full;
    assign udf_evt = rd_en & flags_q.empty;

    always_comb begin
        fill_d                = FW'(calc_next_fill(32'(fill_q), wr_ack, rd_ack));
        // Flags come from the next fill so they move on the same edge as fill_level.
        flags_d.full          = (fill_d == DEPTH);
        flags_d.halffull      = (fill_d >= HALF);
        flags_d.almost_full   = (fill_d >= af_thresh);
        flags_d.empty         = (fill_d == '0);
        flags_d.almost_empty  = (fill_d <= ae_thresh);
        // A new error wins over a coincident clear.
        ovf_sticky_d          = ovf_evt | (ovf_sticky_q & ~err_clr);
        udf_sticky_d          = udf_evt | (udf_sticky_q & ~err_clr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill_q        <= '0;
            flags_q       <= FLAGS_RESET;
            r_empty_dly_q <= 1'b1;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
            ovf_sticky_q  <= 1'b0;
            udf_sticky_q  <= 1'b0;
        end else begin
            fill_q        <= fill_d;
            flags_q       <= flags_d;
            r_empty_dly_q <= flags_q.empty;
            overflow_q    <= ovf_evt;
            underflow_q   <= udf_evt;
            ovf_sticky_q  <= ovf_sticky_d;
            udf_sticky_q  <= udf_sticky_d;
        end
    end

    sfifo_fill_ptr #(.G_DEPTH(G_MEMDEPTH)) u_wr_ptr (
        .clk    (clk),
        .rst    (rst),
        .inc_i  (wr_ack),
        .addr_o (wr_addr)
    );

    sfifo_fill_ptr #(.G_DEPTH(G_MEMDEPTH)) u_rd_ptr (
        .clk    (clk),
        .rst    (rst),
        .inc_i  (rd_ack),
        .addr_o (rd_addr)
    );

`ifdef SFIFO_FILL_CTRL_WATERMARK_EN
    logic [FW-1:0] peak_q, peak_d;

    always_comb begin
        peak_d = (fill_d > peak_q) ? fill_d : peak_q;
        if (err_clr) begin
            peak_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak_level = peak_q;
`endif

    // FWFT holds empty one extra cycle so the RAM read has landed first.
    assign empty        = (G_FWFT != 0) ? (flags_q.empty | r_empty_dly_q) : flags_q.empty;
    assign fill_level   = fill_q;
    assign full         = flags_q.full;
    assign halffull     = flags_q.halffull;
    assign almost_full  = flags_q.almost_full;
    assign almost_empty = flags_q.almost_empty;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign ovf_sticky   = ovf_sticky_q;
    assign udf_sticky   = udf_sticky_q;

endmodule

// File: tb/tb_sfifo_fill_ctrl.sv
// tb/tb_sfifo_fill_ctrl.sv - scoreboard bench for sfifo_fill_ctrl (depth 6, FWFT 0 and 1)
module tb_sfifo_fill_ctrl;

    localparam int D  = 6;
    localparam int AW = 3;
    localparam int FW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic wr_en = 1'b0, rd_en = 1'b0, err_clr = 1'b0;
    logic [FW-1:0] af_thresh = 4'd4;
    logic [FW-1:0] ae_thresh = 4'd1;

    logic          wr_ack, rd_ack, full, halffull, almost_full, empty, almost_empty;
    logic          overflow, underflow, ovf_sticky, udf_sticky;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [FW-1:0] fill_level;

    logic          f_wr_ack, f_rd_ack, f_full, f_halffull, f_almost_full, f_empty, f_almost_empty;
    logic          f_overflow, f_underflow, f_ovf_sticky, f_udf_sticky;
    logic [AW-1:0] f_wr_addr, f_rd_addr;
    logic [FW-1:0] f_fill_level;
`ifdef SFIFO_FILL_CTRL_WATERMARK_EN
    logic [FW-1:0] peak_level, f_peak_level;
`endif

    always #5 clk = ~clk;

    sfifo_fill_ctrl #(.G_FWFT(0), .G_MEMDEPTH(D)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .af_thresh(af_thresh), .ae_thresh(ae_thresh), .err_clr(err_clr),
        .wr_ack(wr_ack), .rd_ack(rd_ack), .wr_addr(wr_addr), .rd_addr(rd_addr),
        .fill_level(fill_level), .full(full), .halffull(halffull),
        .almost_full(almost_full), .empty(empty), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow),
        .ovf_sticky(ovf_sticky), .udf_sticky(udf_sticky)
`ifdef SFIFO_FILL_CTRL_WATERMARK_EN
        , .peak_level(peak_level)
`endif
    );

    sfifo_fill_ctrl #(.G_FWFT(1), .G_MEMDEPTH(D)) dut_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .af_thresh(af_thresh), .ae_thresh(ae_thresh), .err_clr(err_clr),
        .wr_ack(f_wr_ack), .rd_ack(f_rd_ack), .wr_addr(f_wr_addr), .rd_addr(f_rd_addr),
        .fill_level(f_fill_level), .full(f_full), .halffull(f_halffull),
        .almost_full(f_almost_full), .empty(f_empty), .almost_empty(f_almost_empty),
        .overflow(f_overflow), .underflow(f_underflow),
        .ovf_sticky(f_ovf_sticky), .udf_sticky(f_udf_sticky)
`ifdef SFIFO_FILL_CTRL_WATERMARK_EN
        , .peak_level(f_peak_level)
`endif
    );

    typedef struct {
        bit rst;
        bit wr;
        bit rd;
        bit clr;
        int fill;   // hand-computed occupancy after this cycle's edge
    } vec_t;

    typedef struct {
        int idx;
        bit wr_ack, rd_ack;
        int wa, ra, fill;
        bit full, half, af, empty, ae;
        bit ovf, udf, ovfs, udfs, empty_fwft;
        int peak;
    } exp_t;

    localparam int NV = 24;
    vec_t vecs [NV] = '{
        '{0,0,0,0,0},   // reset
        '{1,1,0,0,1}, '{1,1,0,0,2}, '{1,1,0,0,3},
        '{1,1,0,0,4}, '{1,1,0,0,5}, '{1,1,0,0,6},   // fill to full, wr_addr wraps
        '{1,1,1,0,5},   // full + both: read only, overflow
        '{1,0,0,0,5},
        '{1,0,1,0,4}, '{1,0,1,0,3}, '{1,0,1,0,2}, '{1,0,1,0,1}, '{1,0,1,0,0},
        '{1,1,1,0,1},   // empty + both: write only, underflow
        '{1,0,0,1,1},   // clear sticky bits
        '{1,0,1,0,0},
        '{1,1,0,0,1},   // single write from empty (FWFT latency)
        '{1,0,0,0,1},
        '{1,1,0,0,2},
        '{0,0,0,0,0},   // async reset mid-operation
        '{1,0,0,0,0},
        '{1,0,1,1,0},   // underflow coincident with err_clr: set wins
        '{1,0,0,0,0}
    };

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL vec%0d %s: got %0h expected %0h", idx, name, act, exp);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare the oldest expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("wr_ack",       e.idx, 32'(wr_ack),       32'(e.wr_ack));
            chk("rd_ack",       e.idx, 32'(rd_ack),       32'(e.rd_ack));
            chk("wr_addr",      e.idx, 32'(wr_addr),      32'(e.wa));
            chk("rd_addr",      e.idx, 32'(rd_addr),      32'(e.ra));
            chk("fill_level",   e.idx, 32'(fill_level),   32'(e.fill));
            chk("full",         e.idx, 32'(full),         32'(e.full));
            chk("halffull",     e.idx, 32'(halffull),     32'(e.half));
            chk("almost_full",  e.idx, 32'(almost_full),  32'(e.af));
            chk("empty",        e.idx, 32'(empty),        32'(e.empty));
            chk("almost_empty", e.idx, 32'(almost_empty), 32'(e.ae));
            chk("overflow",     e.idx, 32'(overflow),     32'(e.ovf));
            chk("underflow",    e.idx, 32'(underflow),    32'(e.udf));
            chk("ovf_sticky",   e.idx, 32'(ovf_sticky),   32'(e.ovfs));
            chk("udf_sticky",   e.idx, 32'(udf_sticky),   32'(e.udfs));
            chk("fwft_empty",   e.idx, 32'(f_empty),      32'(e.empty_fwft));
            chk("fwft_fill",    e.idx, 32'(f_fill_level), 32'(e.fill));
`ifdef SFIFO_FILL_CTRL_WATERMARK_EN
            chk("peak_level",   e.idx, 32'(peak_level),   32'(e.peak));
`endif
        end
    end

    // Reference state (fill itself comes from the hand-computed vector table).
    int m_fill, m_wa, m_ra, m_peak;
    bit m_ovf, m_udf, m_ovfs, m_udfs, m_dly;

    task automatic model_reset();
        m_fill = 0; m_wa = 0; m_ra = 0; m_peak = 0;
        m_ovf = 0; m_udf = 0; m_ovfs = 0; m_udfs = 0; m_dly = 1;
    endtask

    initial begin
        exp_t e;
        bit   wa, ra;
        int   guard;
        model_reset();
        repeat (2) @(posedge clk);
        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1;
            rst     = vecs[i].rst;
            wr_en   = vecs[i].wr;
            rd_en   = vecs[i].rd;
            err_clr = vecs[i].clr;
            if (!vecs[i].rst) model_reset();
            wa = vecs[i].wr && (m_fill != D);
            ra = vecs[i].rd && (m_fill != 0);
            e.idx = i;
            e.wr_ack = wa; e.rd_ack = ra;
            e.wa = m_wa; e.ra = m_ra; e.fill = m_fill;
            e.full = (m_fill == D); e.half = (m_fill >= D / 2);
            e.af = (m_fill >= 4); e.empty = (m_fill == 0); e.ae = (m_fill <= 1);
            e.ovf = m_ovf; e.udf = m_udf; e.ovfs = m_ovfs; e.udfs = m_udfs;
            e.empty_fwft = (m_fill == 0) || m_dly;
            e.peak = m_peak;
            sb.push_back(e);
            if (vecs[i].rst) begin
                m_ovf  = vecs[i].wr && (m_fill == D);
                m_udf  = vecs[i].rd && (m_fill == 0);
                m_ovfs = m_ovf || (m_ovfs && !vecs[i].clr);
                m_udfs = m_udf || (m_udfs && !vecs[i].clr);
                m_dly  = (m_fill == 0);
                if (wa) m_wa = (m_wa + 1) % D;
                if (ra) m_ra = (m_ra + 1) % D;
                m_fill = vecs[i].fill;
                m_peak = vecs[i].clr ? 0 : ((m_fill > m_peak) ? m_fill : m_peak);
            end
        end
        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        if (sb.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
